ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_host_tx_if.sv | 17 +
 rtl/ps2_line_sync.sv | 54 +++++
 rtl/ps2_host_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter and receiver.
//   - ps2_state_e : host-to-device transmit FSM states
//   - frame constants : edge count of a host-to-device frame, ACK edge index
//   - default timing constants for 100 MHz clk
//   - odd_parity() : PS/2 parity bit for a data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam int unsigned TMR_W = 21;
  localparam int unsigned IDX_W = 4;

  // Falling edges of a host-to-device frame: 8 data, parity, stop, ACK.
  localparam int unsigned     FRAME_EDGES = 11;
  localparam logic [IDX_W-1:0] EDGE_LAST_DATA = 4'd8;
  localparam logic [IDX_W-1:0] EDGE_PARITY    = 4'd9;
  localparam logic [IDX_W-1:0] EDGE_STOP      = 4'd10;
  localparam logic [IDX_W-1:0] EDGE_ACK       = 4'(FRAME_EDGES);

  // The line filter updates on the 4th consecutive differing sample.
  localparam logic [1:0] FILT_LAST = 2'd3;

  localparam int unsigned DEF_INHIBIT_CYCLES     = 12000;
  localparam int unsigned DEF_REQ_CYCLES         = 200;
  localparam int unsigned DEF_FIRST_EDGE_TIMEOUT = 1500000;
  localparam int unsigned DEF_BIT_TIMEOUT        = 200000;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte-level handshake between a command source and the
// PS/2 host transmitter.
//   tx_valid/tx_data : request and command byte (source -> transmitter)
//   tx_ready         : transmitter idle, accepts on tx_valid && tx_ready
//   busy             : transfer in progress
//   tx_done / tx_err : one-cycle completion / failure pulses
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (output tx_valid, tx_data, input tx_ready, busy, tx_done, tx_err);
  modport slave  (input tx_valid, tx_data, output tx_ready, busy, tx_done, tx_err);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: conditions one raw PS/2 pad level.
//   clk, rst : system clock, synchronous active-high reset
//   pad_in   : raw pad level (asynchronous)
//   level    : filtered level, changes after 4 consecutive equal samples
//   fall     : one-cycle pulse when the filtered level goes 1 -> 0
module ps2_line_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pad_in,
  output logic level,
  output logic fall
);

  logic [1:0] sync_q, sync_d;
  logic [1:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;
  logic       fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[0], pad_in};
    cnt_d  = cnt_q;
    filt_d = filt_q;
    // cnt_q counts consecutive samples that disagree with the filtered level.
    if (sync_q[1] == filt_q) begin
      cnt_d = 2'd0;
    end else if (cnt_q == FILT_LAST) begin
      filt_d = sync_q[1];
      cnt_d  = 2'd0;
    end else begin
      cnt_d = cnt_q + 2'd1;
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= 2'd0;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
    end
  end

  assign level = filt_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//   clk, rst         : 100 MHz system clock, synchronous active-high reset
//   tx_if (slave)    : tx_valid/tx_data in; tx_ready, busy, tx_done, tx_err out
//   ps2c_in/ps2d_in  : raw PS2C/PS2D pad levels
//   ps2c_oe/ps2d_oe  : 1 = pull the line low, 0 = release to the pull-up
//
// state        | meaning
// ST_IDLE      | lines released, waiting for tx_valid
// ST_INHIBIT   | clock held low, data released
// ST_REQ       | clock and data low (start bit / request-to-send)
// ST_SHIFT     | clock released, next bit driven on each device falling edge
// ST_ACK       | waiting for edge 11 to sample the device ACK
// ST_WAIT_IDLE | waiting for both lines to return high
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES     = DEF_INHIBIT_CYCLES,
  parameter int unsigned REQ_CYCLES         = DEF_REQ_CYCLES,
  parameter int unsigned FIRST_EDGE_TIMEOUT = DEF_FIRST_EDGE_TIMEOUT,
  parameter int unsigned BIT_TIMEOUT        = DEF_BIT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  tx_if,
  input  logic          ps2c_in,
  input  logic          ps2d_in,
  output logic          ps2c_oe,
  output logic          ps2d_oe
);

  // The timer counts down to zero, so each phase loads its length minus one.
  localparam logic [TMR_W-1:0] INH_LOAD   = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] REQ_LOAD   = TMR_W'(REQ_CYCLES - 1);
  localparam logic [TMR_W-1:0] FIRST_LOAD = TMR_W'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] BIT_LOAD   = TMR_W'(BIT_TIMEOUT - 1);

  logic c_level, c_fall, d_level;
  // The transmitter never needs data-line edges, only its level.
  logic d_fall_unused;

  ps2_line_sync u_sync_c (.clk(clk), .rst(rst), .pad_in(ps2c_in), .level(c_level), .fall(c_fall));
  ps2_line_sync u_sync_d (.clk(clk), .rst(rst), .pad_in(ps2d_in), .level(d_level), .fall(d_fall_unused));

  ps2_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             c_oe_q, c_oe_d;
  logic             d_oe_q, d_oe_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             abort;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    c_oe_d  = c_oe_q;
    d_oe_d  = d_oe_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    abort   = 1'b0;
    idx_nxt = idx_q + 4'd1;

    case (state_q)
      ST_IDLE: begin
        if (tx_if.tx_valid) begin
          data_d  = tx_if.tx_data;
          par_d   = odd_parity(tx_if.tx_data);
          tmr_d   = INH_LOAD;
          idx_d   = '0;
          c_oe_d  = 1'b1;
          d_oe_d  = 1'b0;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (tmr_q == '0) begin
          tmr_d   = REQ_LOAD;
          d_oe_d  = 1'b1;
          state_d = ST_REQ;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_REQ: begin
        // Releasing the clock with data still low hands the clock to the device.
        if (tmr_q == '0) begin
          tmr_d   = FIRST_LOAD;
          c_oe_d  = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (c_fall) begin
          idx_d = idx_nxt;
          tmr_d = BIT_LOAD;
          if (idx_nxt <= EDGE_LAST_DATA) begin
            d_oe_d = ~data_q[idx_q[2:0]];
          end else if (idx_nxt == EDGE_PARITY) begin
            d_oe_d = ~par_q;
          end else begin
            d_oe_d  = 1'b0;
            state_d = ST_ACK;
          end
        end else if (tmr_q == '0) begin
          abort = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_ACK: begin
        if (c_fall) begin
          idx_d = idx_nxt;
          if (!d_level) begin
            tmr_d   = BIT_LOAD;
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (tmr_q == '0) begin
          abort = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (c_level && d_level) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          abort = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: begin
        abort = 1'b1;
      end
    endcase

    if (abort) begin
      err_d   = 1'b1;
      c_oe_d  = 1'b0;
      d_oe_d  = 1'b0;
      state_d = ST_IDLE;
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      c_oe_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      c_oe_q  <= c_oe_d;
      d_oe_q  <= d_oe_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ps2c_oe        = c_oe_q;
  assign ps2d_oe        = d_oe_q;
  assign tx_if.tx_ready = ready_q;
  assign tx_if.busy     = busy_q;
  assign tx_if.tx_done  = done_q;
  assign tx_if.tx_err   = err_q;

endmodule
